dlx_branch_predict_unit: RTL and testbench

DLX_BRANCH_PREDICT_UNIT -- requirements
Module: dlx_branch_predict_unit

---
 rtl/dlx_branch_predict_unit_if.sv | 29 ++
 rtl/dlx_branch_predict_unit.sv | 154 +++++++++++++++
 tb/tb_dlx_branch_predict_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/dlx_branch_predict_unit_if.sv
// Fetch-side lookup and resolve-stage signals of the DLX branch predictor, bundled.
// The master side drives the fetch PC and the resolve inputs, and the slave side returns predictions, redirects and link writes.
interface dlx_branch_predict_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] if_pc;
    logic             pred_taken;
    logic [WIDTH-1:0] pred_target;
    logic             ex_valid;
    logic [31:0]      ex_instr;
    logic [WIDTH-1:0] ex_pc_plus_four;
    logic [WIDTH-1:0] ex_rs1;
    logic             ex_pred_taken;
    logic [WIDTH-1:0] ex_pred_target;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             link_we;
    logic [WIDTH-1:0] link_data;
    logic [15:0]      mispredict_count;

    modport master (
        output if_pc, ex_valid, ex_instr, ex_pc_plus_four, ex_rs1, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, redirect_valid, redirect_pc, link_we, link_data, mispredict_count
    );
    modport slave (
        input  if_pc, ex_valid, ex_instr, ex_pc_plus_four, ex_rs1, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, redirect_valid, redirect_pc, link_we, link_data, mispredict_count
    );
endinterface

// File: rtl/dlx_branch_predict_unit.sv
// DLX branch predictor: direct-mapped BTB with 2-bit counters plus resolve/redirect logic.
// Lookup is combinational, resolution is registered one cycle later, and there is no backpressure.
module dlx_branch_predict_unit #(
    parameter int WIDTH       = 32,
    parameter int BTB_DEPTH   = 16,
    parameter int LINK_OFFSET = 4
) (
    input logic                     clk,
    input logic                     reset,
    dlx_branch_predict_unit_if.slave bp
);
    localparam int IDX  = $clog2(BTB_DEPTH);
    localparam int TAGW = WIDTH - IDX - 2;

    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQZ = 6'h04;
    localparam logic [5:0] OP_BNEZ = 6'h05;
    localparam logic [5:0] OP_JR   = 6'h12;
    localparam logic [5:0] OP_JALR = 6'h13;

    logic             btb_vld_q [BTB_DEPTH];
    logic [TAGW-1:0]  btb_tag_q [BTB_DEPTH];
    logic [WIDTH-1:0] btb_tgt_q [BTB_DEPTH];
    logic [1:0]       btb_ctr_q [BTB_DEPTH];

    logic             redirect_valid_q, redirect_valid_d;
    logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic             link_we_q, link_we_d;
    logic [WIDTH-1:0] link_data_q, link_data_d;
    logic [15:0]      mispredict_count_q, mispredict_count_d;

    // Fetch-side lookup always sees the pre-update array contents.
    logic [IDX-1:0] lk_idx;
    logic           lk_hit;
    assign lk_idx         = bp.if_pc[IDX+1:2];
    assign lk_hit         = btb_vld_q[lk_idx] && (btb_tag_q[lk_idx] == bp.if_pc[WIDTH-1:IDX+2]);
    assign bp.pred_taken  = lk_hit && btb_ctr_q[lk_idx][1];
    assign bp.pred_target = bp.pred_taken ? btb_tgt_q[lk_idx] : '0;

    logic [5:0]       opcode;
    logic             is_cond, is_uncond, is_ctrl, is_link, taken, mispredict;
    logic [WIDTH-1:0] target, next_pc;

    always_comb begin
        opcode    = bp.ex_instr[31:26];
        is_cond   = (opcode == OP_BEQZ) || (opcode == OP_BNEZ);
        is_uncond = (opcode == OP_J) || (opcode == OP_JAL) || (opcode == OP_JR) || (opcode == OP_JALR);
        is_ctrl   = is_cond || is_uncond;
        is_link   = (opcode == OP_JAL) || (opcode == OP_JALR);
        target    = '0;
        taken     = 1'b0;
        case (opcode)
            OP_J, OP_JAL: begin
                target = bp.ex_pc_plus_four + {{(WIDTH-26){bp.ex_instr[25]}}, bp.ex_instr[25:0]};
                taken  = 1'b1;
            end
            OP_BEQZ, OP_BNEZ: begin
                target = bp.ex_pc_plus_four + {{(WIDTH-16){bp.ex_instr[15]}}, bp.ex_instr[15:0]};
                taken  = (bp.ex_rs1 == '0) ^ (opcode == OP_BNEZ);
            end
            OP_JR, OP_JALR: begin
                target = bp.ex_rs1;
                taken  = 1'b1;
            end
            default: ;
        endcase
        next_pc    = taken ? target : bp.ex_pc_plus_four;
        mispredict = (taken != bp.ex_pred_taken) || (taken && (target != bp.ex_pred_target));
    end

    logic [WIDTH-1:0] up_pc;
    logic [IDX-1:0]   up_idx;
    logic [TAGW-1:0]  up_tag;
    logic             up_hit, up_we;
    logic [1:0]       up_ctr_d;
    logic [WIDTH-1:0] up_tgt_d;

    assign up_pc  = bp.ex_pc_plus_four - WIDTH'(4);
    assign up_idx = up_pc[IDX+1:2];
    assign up_tag = up_pc[WIDTH-1:IDX+2];
    assign up_hit = btb_vld_q[up_idx] && (btb_tag_q[up_idx] == up_tag);

    always_comb begin
        up_we    = 1'b0;
        up_ctr_d = btb_ctr_q[up_idx];
        up_tgt_d = btb_tgt_q[up_idx];
        if (bp.ex_valid && is_ctrl) begin
            if (up_hit) begin
                up_we = 1'b1;
                if (is_uncond) begin
                    up_ctr_d = 2'd3;
                    up_tgt_d = target;
                end else if (taken) begin
                    up_ctr_d = (btb_ctr_q[up_idx] == 2'd3) ? 2'd3 : btb_ctr_q[up_idx] + 2'd1;
                    up_tgt_d = target;
                end else begin
                    up_ctr_d = (btb_ctr_q[up_idx] == 2'd0) ? 2'd0 : btb_ctr_q[up_idx] - 2'd1;
                end
            end else if (taken) begin
                up_we    = 1'b1;
                up_ctr_d = is_uncond ? 2'd3 : 2'd2;
                up_tgt_d = target;
            end
        end
    end

    always_comb begin
        redirect_valid_d   = bp.ex_valid && mispredict;
        redirect_pc_d      = bp.ex_valid ? next_pc : redirect_pc_q;
        link_we_d          = bp.ex_valid && is_link;
        link_data_d        = link_we_d ? bp.ex_pc_plus_four + WIDTH'(LINK_OFFSET) : link_data_q;
        mispredict_count_d = mispredict_count_q;
        if (redirect_valid_d && (mispredict_count_q != 16'hFFFF)) begin
            mispredict_count_d = mispredict_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_vld_q[i] <= 1'b0;
                btb_ctr_q[i] <= 2'd0;
            end
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= '0;
            link_we_q          <= 1'b0;
            link_data_q        <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (up_we) begin
                btb_vld_q[up_idx] <= 1'b1;
                btb_tag_q[up_idx] <= up_tag;
                btb_tgt_q[up_idx] <= up_tgt_d;
                btb_ctr_q[up_idx] <= up_ctr_d;
            end
            redirect_valid_q   <= redirect_valid_d;
            redirect_pc_q      <= redirect_pc_d;
            link_we_q          <= link_we_d;
            link_data_q        <= link_data_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign bp.redirect_valid   = redirect_valid_q;
    assign bp.redirect_pc      = redirect_pc_q;
    assign bp.link_we          = link_we_q;
    assign bp.link_data        = link_data_q;
    assign bp.mispredict_count = mispredict_count_q;

    // Word-offset bits never address the BTB.
    logic unused_ok;
    assign unused_ok = &{1'b0, bp.if_pc[1:0], up_pc[1:0]};
endmodule

// File: tb/tb_dlx_branch_predict_unit.sv
// Scoreboard bench: a queue-based BTB/resolve model predicts lookups and registered outputs per cycle.
module tb_dlx_branch_predict_unit;
    localparam int W = 32;
    localparam int D = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dlx_branch_predict_unit_if #(.WIDTH(W)) bp();
    dlx_branch_predict_unit #(.WIDTH(W), .BTB_DEPTH(D), .LINK_OFFSET(4)) dut (
        .clk(clk), .reset(reset), .bp(bp)
    );

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        lwe;
        logic [31:0] ldat;
        logic [15:0] cnt;
    } reg_exp_t;
    typedef struct {
        logic        pt;
        logic [31:0] ptgt;
    } lk_exp_t;

    reg_exp_t rg_q[$];
    lk_exp_t  lk_q[$];

    bit          mv  [D];
    int unsigned mtag[D];
    logic [31:0] mtgt[D];
    int          mctr[D];
    reg_exp_t    cur;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic lk_exp_t model_lookup(input logic [31:0] pc);
        int unsigned idx = (pc / 4) % D;
        int unsigned tag = pc / (4 * D);
        lk_exp_t r;
        r.pt   = mv[idx] && (mtag[idx] == tag) && (mctr[idx] >= 2);
        r.ptgt = r.pt ? mtgt[idx] : 32'h0;
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < D; i++) begin
            mv[i]   = 1'b0;
            mctr[i] = 0;
        end
        cur = '{1'b0, 32'h0, 1'b0, 32'h0, 16'h0};
    endtask

    task automatic step(input logic rst, input logic v, input logic [31:0] instr,
                        input logic [31:0] ppf, input logic [31:0] rs1, input logic pt,
                        input logic [31:0] ptgt, input logic [31:0] ifpc);
        int          op, s;
        bit          cond, uncond, taken, mis;
        logic [31:0] tgt, nxt, upc;
        int unsigned idx, tag;
        @(negedge clk);
        reset = rst;  bp.ex_valid = v;  bp.ex_instr = instr;  bp.ex_pc_plus_four = ppf;
        bp.ex_rs1 = rs1;  bp.ex_pred_taken = pt;  bp.ex_pred_target = ptgt;  bp.if_pc = ifpc;
        lk_q.push_back(model_lookup(ifpc));
        if (rst) begin
            model_clear();
        end else if (!v) begin
            cur.rv  = 1'b0;
            cur.lwe = 1'b0;
        end else begin
            op     = int'(instr[31:26]);
            cond   = (op == 4) || (op == 5);
            uncond = (op == 2) || (op == 3) || (op == 'h12) || (op == 'h13);
            tgt    = 32'h0;
            if (op == 2 || op == 3) begin
                s = int'(instr[25:0]);
                if (s >= 33554432) s -= 67108864;
                tgt = ppf + 32'(s);
            end else if (cond) begin
                s = int'(instr[15:0]);
                if (s >= 32768) s -= 65536;
                tgt = ppf + 32'(s);
            end else if (uncond) begin
                tgt = rs1;
            end
            taken = uncond || (op == 4 && rs1 == 0) || (op == 5 && rs1 != 0);
            nxt   = taken ? tgt : ppf;
            mis   = (taken != pt) || (taken && tgt != ptgt);
            cur.rv  = mis;
            cur.rpc = nxt;
            cur.lwe = (op == 3) || (op == 'h13);
            if (cur.lwe) cur.ldat = ppf + 4;
            if (mis && cur.cnt != 16'hFFFF) cur.cnt = cur.cnt + 1;
            upc = ppf - 4;
            idx = (upc / 4) % D;
            tag = upc / (4 * D);
            if (cond || uncond) begin
                if (mv[idx] && mtag[idx] == tag) begin
                    if (uncond) mctr[idx] = 3;
                    else if (taken) mctr[idx] = (mctr[idx] + 1 > 3) ? 3 : mctr[idx] + 1;
                    else mctr[idx] = (mctr[idx] - 1 < 0) ? 0 : mctr[idx] - 1;
                    if (taken) mtgt[idx] = tgt;
                end else if (taken) begin
                    mv[idx]   = 1'b1;
                    mtag[idx] = tag;
                    mtgt[idx] = tgt;
                    mctr[idx] = uncond ? 3 : 2;
                end
            end
        end
        rg_q.push_back(cur);
    endtask

    task automatic idle(input logic [31:0] ifpc);
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, ifpc);
    endtask

    // Registered outputs settle after the edge that consumed the stimulus.
    always @(posedge clk) begin
        reg_exp_t e;
        #1;
        if (rg_q.size() > 0) begin
            e = rg_q.pop_front();
            check("redirect_valid",   32'(bp.redirect_valid),   32'(e.rv));
            check("redirect_pc",      bp.redirect_pc,           e.rpc);
            check("link_we",          32'(bp.link_we),          32'(e.lwe));
            check("link_data",        bp.link_data,             e.ldat);
            check("mispredict_count", 32'(bp.mispredict_count), 32'(e.cnt));
        end
    end

    always @(negedge clk) begin
        lk_exp_t e;
        #1;
        if (lk_q.size() > 0) begin
            e = lk_q.pop_front();
            check("pred_taken",  32'(bp.pred_taken), 32'(e.pt));
            check("pred_target", bp.pred_target,     e.ptgt);
        end
    end

    localparam logic [5:0] OPS [9] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h12, 6'h13, 6'h00, 6'h08, 6'h23};

    initial begin
        logic [31:0] pc, rs1, ifpc, ptgt, instr;
        logic        pt;
        lk_exp_t     l;
        reset = 1'b1;  bp.ex_valid = 1'b0;  bp.ex_instr = '0;  bp.ex_pc_plus_four = '0;
        bp.ex_rs1 = '0;  bp.ex_pred_taken = 1'b0;  bp.ex_pred_target = '0;  bp.if_pc = '0;
        model_clear();
        repeat (2) @(posedge clk);

        step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h100);
        idle(32'h100);
        step(1'b0, 1'b1, {6'h03, 26'h10}, 32'h104, 32'h0, 1'b0, 32'h0, 32'h100);
        idle(32'h100);
        step(1'b0, 1'b1, {6'h04, 10'h0, 16'hFFF8}, 32'h204, 32'h0, 1'b0, 32'h0, 32'h200);
        step(1'b0, 1'b1, {6'h04, 10'h0, 16'hFFF8}, 32'h204, 32'h5, 1'b1, 32'h1FC, 32'h200);
        idle(32'h200);
        step(1'b0, 1'b1, {6'h12, 26'h0}, 32'h304, 32'h4000, 1'b1, 32'h3000, 32'h300);
        step(1'b0, 1'b1, {6'h05, 10'h0, 16'h0020}, 32'h404, 32'h1, 1'b0, 32'h0, 32'h400);
        step(1'b0, 1'b1, {6'h05, 10'h0, 16'h0020}, 32'h404, 32'h1, 1'b1, 32'h424, 32'h400);
        idle(32'h400);

        for (int i = 0; i < 3000; i++) begin
            pc    = 32'h100 + 4 * $urandom_range(0, 63);
            instr = {OPS[$urandom_range(0, 8)], 26'($urandom)};
            if ($urandom_range(0, 1) == 1) instr[25:16] = 10'($urandom_range(0, 1) ? 10'h3FF : 10'h0);
            case ($urandom_range(0, 2))
                0: rs1 = 32'h0;
                1: rs1 = 32'h100 + 4 * $urandom_range(0, 63);
                default: rs1 = $urandom;
            endcase
            l = model_lookup(pc);
            if ($urandom_range(0, 1) == 1) begin
                pt = l.pt;  ptgt = l.ptgt;
            end else begin
                pt = 1'($urandom);  ptgt = 32'h100 + 4 * $urandom_range(0, 63);
            end
            ifpc = ($urandom_range(0, 1) == 1) ? pc : 32'h100 + 4 * $urandom_range(0, 63);
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0), instr, pc + 4, rs1, pt, ptgt, ifpc);
        end

        for (int i = 0; i < 65540; i++) begin
            step(1'b0, 1'b1, {6'h02, 26'h0}, 32'h504, 32'h0, 1'b0, 32'h0, 32'h500);
        end
        step(1'b1, 1'b1, {6'h03, 26'h10}, 32'h104, 32'h0, 1'b0, 32'h0, 32'h500);
        for (int i = 0; i < 64; i++) idle(32'h100 + 4 * i);
        idle(32'h500);
        idle(32'h100);

        @(posedge clk);
        @(negedge clk);
        #2;
        check("scoreboard_drained", 32'(rg_q.size() + lk_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
